tff_count_ctrl: RTL and testbench
=================================

# tff_count_ctrl

Sequencing controller for a bank of T flip-flops operated as a programmable synchronous counter. Accepts a start request with a direction and a limit, presets the bank through toggle inputs only (T = q XOR target), then drives per-bit toggle enables until the terminal value is reached. Supports one-shot and auto-reload operation, pause via halt, and a start/busy/done handshake. It sits between the lab's TFF primitives and any block needing a timed count (dividers, delay timers).

## Interface
- WIDTH, 4: number of T flip-flops in the bank; count width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin; sampled only in IDLE.
- up  input  1  direction, sampled with start: 1 = count 0→limit, 0 = count limit→0.
- limit  input  WIDTH  terminal/preset value, sampled with start.
- reload  input  1  sampled with start: 1 = auto-reload, 0 = one-shot.
- halt  input  1  freezes counting while high; honoured only in RUN.
- busy  output  1  high in INIT and RUN.
- done  output  1  one-cycle pulse when a one-shot sequence completes.
- tc  output  1  high during the RUN cycle in which count equals target and halt = 0.
- count  output  WIDTH  current TFF bank state q.

## Operation
- Reset (asynchronous, rst_n = 0): state IDLE, all TFFs q = 0, busy = 0, done = 0, tc = 0, latched up/limit/reload cleared. Reset mid-sequence aborts immediately with no done.
- Latched at start acceptance: dir, lim, rl. init = dir ? 0 : lim; target = dir ? lim : 0.
- IDLE: T = 0. start = 1 → INIT (latch fields). Otherwise stay.
- INIT (1 cycle): T = q ^ init, so count = init after the edge. → RUN. start and halt ignored.
- RUN:
  - halt = 1: T = 0, stay; tc = 0.
  - count == target: tc = 1. If rl: T = q ^ init, stay RUN. Else: T = 0, → DONE.
  - Otherwise, up: T[0] = 1, T[i] = &q[i-1:0]. Down: T[0] = 1, T[i] = &~q[i-1:0].
- DONE (1 cycle): done = 1, T = 0. → IDLE. Count holds target.
- start while busy or in DONE is ignored (no queueing).
- Boundaries:
  - limit = 0 completes with a single RUN cycle.
  - limit = 0 with reload gives tc high every RUN cycle.
  - Up to 2^WIDTH−1 reaches all ones without wrap.
  - Count never passes target, so the bank never wraps.

## Timing
- start sampled at edge E0. INIT occupies E0–E1. RUN occupies E1 through E(limit+2), i.e. limit+1 cycles excluding halt cycles.
- done is high from E(limit+2) to E(limit+3); IDLE follows. Each halted cycle adds one cycle.
- Auto-reload period: limit+1 cycles between tc pulses.
- busy, done and count are registered-state outputs. tc is combinational from state, count and halt, and is valid before the next edge.
- Latency from halt deassert to the next count change: 1 edge.

## Structure
- Package tff_ctrl_pkg: state encoding localparams (IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, DONE = 2'd3) and the WIDTH default.
- Sub-module tff_bank #(WIDTH): WIDTH T flip-flops with async active-low clear. Ports: clk, rst_n, t[WIDTH-1:0], q[WIDTH-1:0]. q[i] toggles on the edge when t[i] = 1.
- The controller computes the toggle vector combinationally and holds the state register and latched fields.

## Test plan
- Up one-shot, limit = 3: start at E0 → count 0,1,2,3 over E1–E4; tc high in the count = 3 cycle; done pulse after E5; busy falls with it.
- Down one-shot, limit = 5, bank previously at 3: INIT loads 5 by toggles → count 5,4,3,2,1,0; tc at 0; then done.
- Up reload, limit = 2: count sequence 0,1,2,0,1,2…; tc every 3rd cycle; done never asserts; busy stays high.
- Halt during up count at count = 2 for 4 cycles: count holds 2, tc stays 0; the sequence resumes and done is delayed by exactly 4 cycles.
- limit = 0 up one-shot: 1 RUN cycle with tc = 1; done after E2. A start pulse during RUN has no effect.
- rst_n low mid-count at count = 6 (WIDTH = 4, limit = 15): count = 0, busy = 0 immediately, without waiting for a clock edge. No done pulse occurs. A new start after release runs normally.

Source files
------------

// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the TFF counter controller: FSM state encoding and default bank width.
package tff_ctrl_pkg;

    localparam int TFF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Request/status bundle for tff_count_ctrl; master drives the request, slave is the controller.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic             reload;
    logic             halt;
    logic             busy;
    logic             done;
    logic             tc;
    logic [WIDTH-1:0] count;

    modport master (
        output start, up, limit, reload, halt,
        input  busy, done, tc, count
    );

    modport slave (
        input  start, up, limit, reload, halt,
        output busy, done, tc, count
    );
endinterface

// File: rtl/tff_count_ctrl_bank.sv
// Bank of T flip-flops with async clear; bit i toggles on the edge when t[i] is high.
// One-edge latency from t to q; no backpressure.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a TFF bank as a programmable up/down counter: one INIT cycle presets, then limit+1 RUN cycles.
// start is dropped (not queued) while busy or in DONE; halt stalls RUN one cycle per high cycle.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    tff_count_ctrl_if.slave  bus
);
    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             rl_q, rl_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] target;
    logic             at_target;
    logic             chain;

    assign init_val  = dir_q ? '0 : lim_q;
    assign target    = dir_q ? lim_q : '0;
    assign at_target = (q == target);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rl_d    = rl_q;
        lim_d   = lim_q;
        t       = '0;
        chain   = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = INIT;
                    dir_d   = bus.up;
                    lim_d   = bus.limit;
                    rl_d    = bus.reload;
                end
            end
            INIT: begin
                // Preset purely through toggles: flip exactly the bits that differ from init.
                t       = q ^ init_val;
                state_d = RUN;
            end
            RUN: begin
                if (!bus.halt) begin
                    if (at_target) begin
                        if (rl_q) begin
                            t = q ^ init_val;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
                        for (int i = 0; i < WIDTH; i++) begin
                            t[i]  = chain;
                            chain = chain & (dir_q ? q[i] : ~q[i]);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == INIT) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            rl_q    <= 1'b0;
            lim_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rl_q    <= rl_d;
            lim_q   <= lim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .q     (q)
    );

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = q;
    assign bus.tc    = (state_q == RUN) && !bus.halt && at_target;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with a cycle-level behavioural model and literal spot checks.
module tb_tff_count_ctrl;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    tff_count_ctrl_if #(.WIDTH(W)) bus ();

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tc_cnt   = 0;
    bit cmp_en   = 1'b0;

    // Model: phase 0 idle, 1 init, 2 run, 3 done; count kept as a plain integer.
    int m_phase = 0;
    int m_count = 0;
    int m_lim   = 0;
    bit m_dir   = 1'b0;
    bit m_rl    = 1'b0;

    function automatic int m_target();
        return m_dir ? m_lim : 0;
    endfunction

    function automatic int m_init();
        return m_dir ? 0 : m_lim;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_count = 0;
            m_lim   = 0;
            m_dir   = 1'b0;
            m_rl    = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_dir   = bus.up;
                    m_lim   = int'(bus.limit);
                    m_rl    = bus.reload;
                    m_phase = 1;
                end
                1: begin
                    m_count = m_init();
                    m_phase = 2;
                end
                2: if (!bus.halt) begin
                    if (m_count == m_target()) begin
                        if (m_rl) m_count = m_init();
                        else      m_phase = 3;
                    end else begin
                        m_count = m_dir ? m_count + 1 : m_count - 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_count", int'(bus.count), m_count);
            chk("cmp_busy", int'(bus.busy), int'(m_phase == 1 || m_phase == 2));
            chk("cmp_done", int'(bus.done), int'(m_phase == 3));
            chk("cmp_tc", int'(bus.tc),
                int'(m_phase == 2 && !bus.halt && m_count == m_target()));
        end
    end

    // Event monitor: samples pre-edge values, so done_cyc is the edge index where done rose.
    always @(posedge clk) begin
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.tc) tc_cnt++;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit u, input int l, input bit r);
        bus.up     = u;
        bus.limit  = l[W-1:0];
        bus.reload = r;
        bus.start  = 1'b1;
        tick();
        e0        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        repeat (64) begin
            tick();
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        if (seen) chk({name, "_done_latency"}, done_cyc - e0, exp_lat);
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_count_async", int'(bus.count), 0);
        chk("rst_busy_async", int'(bus.busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int tc0;
    int d0;

    initial begin
        bus.start  = 1'b0;
        bus.up     = 1'b0;
        bus.limit  = '0;
        bus.reload = 1'b0;
        bus.halt   = 1'b0;

        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("reset_count", int'(bus.count), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_tc", int'(bus.tc), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Up one-shot, limit 3.
        tc0 = tc_cnt;
        go(1'b1, 3, 1'b0);
        @(negedge clk);
        chk("up3_init_busy", int'(bus.busy), 1);
        tick();
        @(negedge clk);
        chk("up3_first_count", int'(bus.count), 0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("up3_count_at_tc", int'(bus.count), 3);
        chk("up3_tc", int'(bus.tc), 1);
        wait_done("up3", 5);
        chk("up3_hold_count", int'(bus.count), 3);
        chk("up3_busy_after", int'(bus.busy), 0);
        chk("up3_done_dropped", int'(bus.done), 0);
        chk("up3_tc_pulses", tc_cnt - tc0, 1);

        // Down one-shot, limit 5, preset from a bank holding 3.
        go(1'b0, 5, 1'b0);
        tick();
        @(negedge clk);
        chk("dn5_preset", int'(bus.count), 5);
        wait_done("dn5", 7);
        chk("dn5_final", int'(bus.count), 0);

        // Up auto-reload, limit 2: ten edges cover INIT plus nine RUN cycles.
        tc0 = tc_cnt;
        d0  = done_cnt;
        go(1'b1, 2, 1'b1);
        repeat (10) tick();
        chk("rl2_tc_pulses", tc_cnt - tc0, 3);
        chk("rl2_no_done", done_cnt - d0, 0);
        chk("rl2_busy", int'(bus.busy), 1);
        chk("rl2_count", int'(bus.count), 0);
        pulse_reset();

        // limit 0 with reload: tc every RUN cycle.
        tc0 = tc_cnt;
        go(1'b1, 0, 1'b1);
        repeat (5) tick();
        chk("rl0_tc_pulses", tc_cnt - tc0, 4);
        pulse_reset();

        // Halt at count 2 for four edges.
        go(1'b1, 5, 1'b0);
        tick(); tick(); tick();
        bus.halt = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("halt_count_frozen", int'(bus.count), 2);
        chk("halt_tc_low", int'(bus.tc), 0);
        tick(); tick();
        bus.halt = 1'b0;
        wait_done("halt", 11);

        // limit 0 one-shot with a stray start during RUN.
        d0 = done_cnt;
        go(1'b1, 0, 1'b0);
        tick();
        bus.start = 1'b1;
        @(negedge clk);
        chk("lim0_tc", int'(bus.tc), 1);
        tick();
        bus.start = 1'b0;
        wait_done("lim0", 2);
        tick(); tick();
        chk("lim0_no_requeue", int'(bus.busy), 0);
        chk("lim0_single_done", done_cnt - d0, 1);

        // Reset mid-count at 6, then a clean restart.
        d0 = done_cnt;
        go(1'b1, 15, 1'b0);
        repeat (7) tick();
        chk("rst_mid_pre_count", int'(bus.count), 6);
        pulse_reset();
        tick(); tick(); tick();
        chk("rst_mid_no_done", done_cnt - d0, 0);
        go(1'b1, 3, 1'b0);
        wait_done("restart", 5);
        chk("restart_final", int'(bus.count), 3);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
